// File: rtl/load_store_unit_if.sv
// Bundle of pipeline request, data-memory and load-result signals around the load/store unit.
// master = pipeline plus data memory side, slave = the load/store unit itself.
interface load_store_unit_if;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] dm_rdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, dm_rdata,
        input  stall, dm_addr, dm_wdata, dm_r, dm_w, load_valid, load_data, misalign_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, dm_rdata,
        output stall, dm_addr, dm_wdata, dm_r, dm_w, load_valid, load_data, misalign_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for a word-wide data memory with one-cycle registered reads.
// Sub-word stores are read-modify-write; sub-word loads are lane-selected and extended.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | accept a request; SW and misaligned accesses finish here
// LOAD_RESP | memory word arrives, extract/extend it and present load_data
// RMW_MERGE | memory word arrives, merge store lanes and write it back
module load_store_unit (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD_RESP, RMW_MERGE} state_t;

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    state_t      state;
    state_t      state_next;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    always_comb begin
        is_load    = bus.req_op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        is_store   = bus.req_op inside {OP_SB, OP_SH, OP_SW};
        misaligned = ((bus.req_op inside {OP_LH, OP_LHU, OP_SH}) && bus.req_addr[0]) ||
                     ((bus.req_op inside {OP_LW, OP_SW}) && (bus.req_addr[1:0] != 2'b00));
        accept     = bus.req_valid && (is_load || is_store) && !misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 16'h0;
        end else if (state == IDLE && accept) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata[15:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_load) begin
                    state_next = LOAD_RESP;
                end else if (accept && bus.req_op != OP_SW) begin
                    state_next = RMW_MERGE;
                end
            end
            LOAD_RESP: state_next = IDLE;
            RMW_MERGE: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Lane extraction and merge work on the word returned for the captured address.
    always_comb begin
        byte_sel = bus.dm_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        case (op_q)
            OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_ext = {24'h0, byte_sel};
            OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {16'h0, half_sel};
            default: load_ext = bus.dm_rdata;
        endcase
        if (op_q == OP_SB) begin
            lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            lane_data = {4{wdata_q[7:0]}};
        end else begin
            lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            lane_data = {2{wdata_q}};
        end
        merged = (bus.dm_rdata & ~lane_mask) | (lane_data & lane_mask);
    end

    always_comb begin
        bus.stall        = 1'b0;
        bus.dm_r         = 1'b0;
        bus.dm_w         = 1'b0;
        bus.dm_wdata     = 32'h0;
        bus.load_valid   = 1'b0;
        bus.load_data    = 32'h0;
        bus.misalign_err = 1'b0;
        bus.dm_addr      = (state == IDLE) ? {bus.req_addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && (is_load || is_store)) begin
                        if (misaligned) begin
                            bus.misalign_err = 1'b1;
                        end else if (bus.req_op == OP_SW) begin
                            bus.dm_w     = 1'b1;
                            bus.dm_wdata = bus.req_wdata;
                        end else begin
                            bus.dm_r  = 1'b1;
                            bus.stall = 1'b1;
                        end
                    end
                end
                LOAD_RESP: begin
                    bus.load_valid = 1'b1;
                    bus.load_data  = load_ext;
                end
                RMW_MERGE: begin
                    bus.dm_w     = 1'b1;
                    bus.dm_wdata = merged;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model over a reference
// memory predicts every cycle's outputs, and directed loads pin the model to known words.
module tb_load_store_unit;
    localparam logic [3:0] LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
    localparam logic [3:0] SB = 4'd8, SH = 4'd9, SW = 4'd10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    // Data memory with registered read plus a back-door write port for preloading.
    logic [31:0] mem [0:63];
    logic [31:0] rdata_q;
    logic        bk_en;
    logic [5:0]  bk_idx;
    logic [31:0] bk_data;
    always @(posedge clk) begin
        if (bk_en) mem[bk_idx] <= bk_data;
        else if (bus.dm_w) mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
        if (bus.dm_r) rdata_q <= mem[bus.dm_addr[7:2]];
    end
    assign bus.dm_rdata = rdata_q;

    logic [31:0] ref_mem [0:63];
    int n_cmp = 0;
    int n_bad = 0;

    logic        exp_en = 1'b0;
    logic        exp_stall, exp_r, exp_w, exp_lv, exp_err, chk_wd, chk_addr;
    logic [31:0] exp_ld, exp_wd, exp_addr;
    logic [31:0] last_load;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_en) begin
            check("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
            check("dm_r", {31'b0, bus.dm_r}, {31'b0, exp_r});
            check("dm_w", {31'b0, bus.dm_w}, {31'b0, exp_w});
            check("rw_exclusive", {31'b0, bus.dm_r & bus.dm_w}, 32'h0);
            check("load_valid", {31'b0, bus.load_valid}, {31'b0, exp_lv});
            check("misalign_err", {31'b0, bus.misalign_err}, {31'b0, exp_err});
            check("load_data", bus.load_data, exp_ld);
            if (chk_wd) check("dm_wdata", bus.dm_wdata, exp_wd);
            if (chk_addr) check("dm_addr", bus.dm_addr, exp_addr);
            if (bus.load_valid) last_load = bus.load_data;
        end
    end

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] mask, ins;
        if (op == SB) begin
            mask = 32'hFF << (8 * off);
            ins  = (wd & 32'hFF) << (8 * off);
        end else begin
            mask = 32'hFFFF << (16 * (off / 2));
            ins  = (wd & 32'hFFFF) << (16 * (off / 2));
        end
        return (old & ~mask) | (ins & mask);
    endfunction

    task automatic quiet_exp();
        exp_en = 1'b1; exp_stall = 0; exp_r = 0; exp_w = 0; exp_lv = 0; exp_err = 0;
        exp_ld = 32'h0; exp_wd = 32'h0; chk_wd = 0; chk_addr = 0; exp_addr = 32'h0;
    endtask

    task automatic run_req(input logic v, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input bit rst_mid);
        logic is_ld, is_st, mis;
        logic [5:0] idx;
        @(posedge clk); #1;
        rst = 1'b0; bk_en = 1'b0;
        bus.req_valid = v; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
        is_ld = op inside {LB, LBU, LH, LHU, LW};
        is_st = op inside {SB, SH, SW};
        mis = ((op inside {LH, LHU, SH}) && addr[0]) || ((op inside {LW, SW}) && addr[1:0] != 2'b00);
        idx = addr[7:2];
        quiet_exp();
        exp_addr = {addr[31:2], 2'b00}; chk_addr = 1;
        if (v && (is_ld || is_st)) begin
            if (mis) exp_err = 1;
            else if (op == SW) begin exp_w = 1; exp_wd = wd; chk_wd = 1; ref_mem[idx] = wd; end
            else begin exp_r = 1; exp_stall = 1; end
        end
        if (v && (is_ld || is_st) && !mis && op != SW) begin
            @(posedge clk); #1;
            // Inputs are ignored in the second cycle, so scramble them.
            bus.req_valid = 1'($urandom); bus.req_op = 4'($urandom);
            bus.req_addr = $urandom; bus.req_wdata = $urandom;
            quiet_exp();
            exp_addr = {addr[31:2], 2'b00};
            if (rst_mid) begin
                rst = 1'b1; chk_wd = 1;
            end else if (is_ld) begin
                chk_addr = 1; exp_lv = 1;
                exp_ld = model_load(op, addr[1:0], ref_mem[idx]);
            end else begin
                chk_addr = 1; exp_w = 1; chk_wd = 1;
                exp_wd = model_merge(op, addr[1:0], ref_mem[idx], wd);
                ref_mem[idx] = exp_wd;
            end
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        rst = 1'b0; bk_en = 1'b1; bk_idx = idx; bk_data = data; ref_mem[idx] = data;
        bus.req_valid = 1'b0;
        quiet_exp();
    endtask

    task automatic pin_load(input string name, input logic [31:0] exp);
        @(negedge clk); #1;
        check(name, last_load, exp);
    endtask

    logic [3:0] ops [8] = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        rst = 1'b1; bk_en = 1'b0; bk_idx = 6'd0; bk_data = 32'h0; last_load = 32'h0;
        bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        // Held in reset while the memory is preloaded; requests must be masked.
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            bk_en = 1'b1; bk_idx = 6'(i);
            bk_data = (i == 4) ? 32'h8899_AABB : $urandom;
            ref_mem[i] = bk_data;
            bus.req_valid = 1'b1; bus.req_op = ops[$urandom_range(0, 7)]; bus.req_addr = $urandom;
            bus.req_wdata = $urandom;
            quiet_exp(); chk_wd = 1;
        end

        run_req(1, LB,  32'h11, 32'h0, 0); pin_load("lb_0x11",  32'hFFFF_FFAA);
        run_req(1, LBU, 32'h11, 32'h0, 0); pin_load("lbu_0x11", 32'h0000_00AA);
        run_req(1, LH,  32'h12, 32'h0, 0); pin_load("lh_0x12",  32'hFFFF_8899);
        run_req(1, LHU, 32'h12, 32'h0, 0); pin_load("lhu_0x12", 32'h0000_8899);
        run_req(1, LW,  32'h10, 32'h0, 0); pin_load("lw_0x10",  32'h8899_AABB);
        run_req(1, SB,  32'h13, 32'h1234_56CC, 0);
        run_req(1, LW,  32'h10, 32'h0, 0); pin_load("lw_after_sb", 32'hCC99_AABB);
        run_req(1, SW,  32'h14, 32'hDEAD_BEEF, 0);
        run_req(1, LW,  32'h14, 32'h0, 0); pin_load("lw_after_sw", 32'hDEAD_BEEF);
        run_req(1, LW,  32'h12, 32'h0, 0);
        run_req(1, SH,  32'h11, 32'hFFFF_FFFF, 0);
        run_req(1, LW,  32'h10, 32'h0, 0); pin_load("lw_after_misalign", 32'hCC99_AABB);
        poke(6'd4, 32'h8899_AABB);
        run_req(1, SH,  32'h10, 32'h0000_1234, 1);
        run_req(0, 4'd0, 32'h0, 32'h0, 0);
        run_req(1, LW,  32'h10, 32'h0, 0); pin_load("lw_after_rst_rmw", 32'h8899_AABB);
        run_req(1, 4'd15, 32'h10, 32'h0, 0);

        for (int i = 0; i < 800; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
            a  = $urandom;
            run_req(($urandom_range(0, 7) != 0), op, a, $urandom, ($urandom_range(0, 15) == 0));
        end

        run_req(0, 4'd0, 32'h0, 32'h0, 0);
        @(posedge clk); #1;
        exp_en = 1'b0;
        for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
